// File: rtl/melody_sequencer.sv
// Score-driven melody sequencer: steps through a 16-entry score, emitting
// note selections with beat-timed durations and articulation gaps.
module melody_sequencer #(
  parameter int unsigned CLOCK_FREQ = 12000000,
  parameter int unsigned BEAT_HZ    = 8,
  parameter int unsigned GAP_CYCLES = 12000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       loop_en,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic [3:0] note_sel,
  output logic       tone_en,
  output logic       busy,
  output logic [3:0] step_idx,
  output logic       done
);

  localparam int unsigned BEAT_CYCLES = CLOCK_FREQ / BEAT_HZ;
  localparam int unsigned DUR_MAX     = 7 * BEAT_CYCLES;
  localparam int unsigned DUR_W       = (DUR_MAX > 1) ? $clog2(DUR_MAX + 1) : 1;
  localparam int unsigned GAP_W       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLAY,
    S_GAP,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         step_q, step_d;
  logic [3:0]         note_q, note_d;
  logic               tone_q, tone_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [DUR_W-1:0]   dur_q, dur_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [7:0]         score_q [16];
  logic [7:0]         score_d [16];

  logic [3:0]         nxt_idx;
  logic [3:0]         adv_idx;
  logic               adv_play;
  logic [3:0]         play_idx;
  logic               go_play;
  logic               go_done;

  // Counter preload: a step lasts beats * BEAT_CYCLES cycles, counting down to 0.
  function automatic logic [DUR_W-1:0] dur_load(input logic [2:0] beats);
    return DUR_W'(32'(beats) * BEAT_CYCLES - 1);
  endfunction

  // Score writes are accepted only while idle.
  always_comb begin
    score_d = score_q;
    if (wr_en && !busy_q) begin
      score_d[wr_addr] = wr_data;
    end
  end

  // Step-advance decision: next entry, else wrap to entry 0 when looping, else finish.
  always_comb begin
    nxt_idx  = step_q + 4'd1;
    adv_play = 1'b0;
    adv_idx  = step_q;
    if (step_q != 4'hF && score_q[nxt_idx][2:0] != 3'd0) begin
      adv_play = 1'b1;
      adv_idx  = nxt_idx;
    end else if (loop_en && score_q[0][2:0] != 3'd0) begin
      adv_play = 1'b1;
      adv_idx  = '0;
    end
  end

  // Next-state and registered-output logic; PLAY/DONE entry is shared by
  // IDLE start and the step-advance paths via go_play/go_done.
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    note_d   = note_q;
    tone_d   = tone_q;
    done_d   = 1'b0;
    dur_d    = dur_q;
    gap_d    = gap_q;
    go_play  = 1'b0;
    go_done  = 1'b0;
    play_idx = adv_idx;

    case (state_q)
      S_IDLE: begin
        tone_d = 1'b0;
        if (start && !stop) begin
          if (score_q[0][2:0] != 3'd0) begin
            go_play  = 1'b1;
            play_idx = '0;
          end else begin
            go_done = 1'b1;
          end
        end
      end
      S_PLAY: begin
        if (stop) begin
          state_d = S_IDLE;
          tone_d  = 1'b0;
        end else if (dur_q != '0) begin
          dur_d = dur_q - DUR_W'(1);
        end else if (GAP_CYCLES != 0) begin
          state_d = S_GAP;
          tone_d  = 1'b0;
          gap_d   = GAP_LOAD;
        end else begin
          go_play = adv_play;
          go_done = !adv_play;
        end
      end
      S_GAP: begin
        if (stop) begin
          state_d = S_IDLE;
          tone_d  = 1'b0;
        end else if (gap_q != '0) begin
          gap_d = gap_q - GAP_W'(1);
        end else begin
          go_play = adv_play;
          go_done = !adv_play;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        tone_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        tone_d  = 1'b0;
      end
    endcase

    if (go_play) begin
      state_d = S_PLAY;
      step_d  = play_idx;
      note_d  = score_q[play_idx][7:4];
      tone_d  = !score_q[play_idx][3];
      dur_d   = dur_load(score_q[play_idx][2:0]);
    end
    if (go_done) begin
      state_d = S_DONE;
      done_d  = 1'b1;
      tone_d  = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  // State, output and score registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      note_q  <= '0;
      tone_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dur_q   <= '0;
      gap_q   <= '0;
      score_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      note_q  <= note_d;
      tone_q  <= tone_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dur_q   <= dur_d;
      gap_q   <= gap_d;
      score_q <= score_d;
    end
  end

  assign note_sel = note_q;
  assign tone_en  = tone_q;
  assign busy     = busy_q;
  assign step_idx = step_q;
  assign done     = done_q;

endmodule
